// File: rtl/swlock_pkg.sv
// Shared types and constants for the switch-sequence lock.
//   state_t      : 3-bit FSM state encoding (IDLE=0 .. LOCKOUT=4)
//   Z_*          : 2-bit status codes presented on the z output
//   timer_width  : width of the shared state timer for a set of limits
package swlock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    localparam logic [1:0] Z_IDLE  = 2'b01;
    localparam logic [1:0] Z_OPEN  = 2'b10;
    localparam logic [1:0] Z_ALERT = 2'b11;

    // One timer serves every timed state, so it must hold the largest limit.
    // A limit of 1 still needs a 1-bit counter.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/swlock_press_detect.sv
// Press detector for the switch-sequence lock.
// Optional macro: SWLOCK_SYNC_EN adds a two-flop synchroniser on sw
// (press latency +2 cycles); without it sw must already be synchronous.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   sw           : raw switch levels
//   press_valid  : press with exactly one switch set
//   press_bad    : press with more than one switch set
//   press_idx    : index of the set switch (meaningful with press_valid)
module swlock_press_detect #(
    parameter int NUM_SW = 4,
    parameter int IDX_W  = $clog2(NUM_SW)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_SW-1:0] sw,
    output logic              press_valid,
    output logic              press_bad,
    output logic [IDX_W-1:0]  press_idx
);

    logic [NUM_SW-1:0] sw_s;

`ifdef SWLOCK_SYNC_EN
    logic [NUM_SW-1:0] sync1_q, sync1_d;
    logic [NUM_SW-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = sw;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sw_s = sync2_q;
`else
    assign sw_s = sw;
`endif

    logic [NUM_SW-1:0] sw_q, sw_d;
    logic              press;
    logic              multi;

    always_comb begin
        sw_d = sw_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_q <= '0;
        end else begin
            sw_q <= sw_d;
        end
    end

    // A press is the first switch going up from all-released; anything that
    // changes while a switch is still held is not a new press.
    assign press       = (sw_q == '0) && (sw_s != '0);
    // Clearing the lowest set bit leaves something only if two or more are set.
    assign multi       = |(sw_s & (sw_s - NUM_SW'(1)));
    assign press_valid = press & ~multi;
    assign press_bad   = press & multi;

    always_comb begin
        press_idx = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            if (sw_s[i]) press_idx = press_idx | IDX_W'(i);
        end
    end

endmodule

// File: rtl/switch_seq_lock.sv
// Switch-sequence lock: accepts a SEQ_LEN-press code on NUM_SW switches,
// with inter-press timeout, failure counting and lockout. The code can be
// rewritten at runtime from IDLE or OPEN.
// Optional macro: SWLOCK_SYNC_EN (input synchroniser in swlock_press_detect).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   sw         : switch levels
//   code_we    : load code_in into the code register (IDLE/OPEN only)
//   code_in    : new code, step i at [i*IDX_W +: IDX_W]
//   state      : current state encoding
//   z          : status code decoded from state
//   step       : correct presses so far
//   fail_cnt   : consecutive failures (saturating)
//   unlock     : one-cycle pulse on entry to OPEN
module switch_seq_lock
    import swlock_pkg::*;
#(
    parameter int NUM_SW      = 4,
    parameter int SEQ_LEN     = 4,
    parameter int TIMEOUT     = 16,
    parameter int OPEN_CYC    = 8,
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 32,
    parameter int IDX_W       = $clog2(NUM_SW),
    parameter int STEP_W      = $clog2(SEQ_LEN + 1),
    parameter int FC_W        = $clog2(MAX_FAIL + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SW-1:0]        sw,
    input  logic                     code_we,
    input  logic [SEQ_LEN*IDX_W-1:0] code_in,
    output logic [2:0]               state,
    output logic [1:0]               z,
    output logic [STEP_W-1:0]        step,
    output logic [FC_W-1:0]          fail_cnt,
    output logic                     unlock
);

    localparam int TMR_W = timer_width(TIMEOUT, OPEN_CYC, LOCKOUT_CYC);

    localparam logic [TMR_W-1:0]  ENTRY_LAST   = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  OPEN_LAST    = TMR_W'(OPEN_CYC - 1);
    localparam logic [TMR_W-1:0]  LOCKOUT_LAST = TMR_W'(LOCKOUT_CYC - 1);
    localparam logic [STEP_W-1:0] STEP_DONE    = STEP_W'(SEQ_LEN);
    localparam logic [FC_W-1:0]   FAIL_SAT     = FC_W'(MAX_FAIL);

    state_t                          state_q, state_d;
    logic [STEP_W-1:0]               step_q, step_d;
    logic [FC_W-1:0]                 fail_cnt_q, fail_cnt_d;
    logic                            unlock_q, unlock_d;
    logic [TMR_W-1:0]                timer_q, timer_d;
    logic [SEQ_LEN-1:0][IDX_W-1:0]   code_q, code_d;
    logic [SEQ_LEN-1:0][IDX_W-1:0]   code_rst;

    logic              press_valid, press_bad, press_any;
    logic [IDX_W-1:0]  press_idx;
    logic [IDX_W-1:0]  exp_idx;
    logic [STEP_W-1:0] step_inc;
    logic              accept_press;

    swlock_press_detect #(
        .NUM_SW (NUM_SW),
        .IDX_W  (IDX_W)
    ) u_press (
        .clk         (clk),
        .reset       (reset),
        .sw          (sw),
        .press_valid (press_valid),
        .press_bad   (press_bad),
        .press_idx   (press_idx)
    );

    assign press_any = press_valid | press_bad;

    // Power-on code is the ascending walk 0,1,2,.. wrapped at NUM_SW.
    for (genvar gi = 0; gi < SEQ_LEN; gi++) begin : g_code_rst
        assign code_rst[gi] = IDX_W'(gi % NUM_SW);
    end

    // Code entry expected at the current step.
    always_comb begin
        exp_idx = code_q[0];
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (step_q == STEP_W'(i)) exp_idx = code_q[i];
        end
    end

    assign step_inc = step_q + STEP_W'(1);

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        fail_cnt_d   = fail_cnt_q;
        code_d       = code_q;
        unlock_d     = 1'b0;
        accept_press = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A code write in the same cycle swallows the press.
                if (code_we) begin
                    code_d = code_in;
                    step_d = '0;
                end else if (press_any) begin
                    if (press_valid && (press_idx == code_q[0])) begin
                        step_d  = STEP_W'(1);
                        state_d = (STEP_W'(1) == STEP_DONE) ? ST_OPEN : ST_ENTRY;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_ENTRY: begin
                // A press on the final idle cycle still counts.
                if (press_any) begin
                    if (press_valid && (press_idx == exp_idx)) begin
                        accept_press = 1'b1;
                        step_d       = step_inc;
                        if (step_inc == STEP_DONE) state_d = ST_OPEN;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end else if (timer_q == ENTRY_LAST) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                end
            end
            ST_OPEN: begin
                if (code_we) begin
                    code_d  = code_in;
                    state_d = ST_IDLE;
                    step_d  = '0;
                end else if (timer_q == OPEN_LAST) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                end
            end
            ST_FAIL: begin
                state_d = (fail_cnt_q == FAIL_SAT) ? ST_LOCKOUT : ST_IDLE;
            end
            ST_LOCKOUT: begin
                if (timer_q == LOCKOUT_LAST) begin
                    state_d    = ST_IDLE;
                    fail_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase

        // Entry actions for OPEN and FAIL.
        if (state_d != state_q) begin
            if (state_d == ST_OPEN) begin
                fail_cnt_d = '0;
                unlock_d   = 1'b1;
            end
            if (state_d == ST_FAIL) begin
                step_d     = '0;
                fail_cnt_d = (fail_cnt_q == FAIL_SAT) ? fail_cnt_q
                                                      : fail_cnt_q + FC_W'(1);
            end
        end

        if ((state_d != state_q) || accept_press) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            fail_cnt_q <= '0;
            unlock_q   <= 1'b0;
            timer_q    <= '0;
            code_q     <= code_rst;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            fail_cnt_q <= fail_cnt_d;
            unlock_q   <= unlock_d;
            timer_q    <= timer_d;
            code_q     <= code_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_OPEN:    z = Z_OPEN;
            ST_FAIL:    z = Z_ALERT;
            ST_LOCKOUT: z = Z_ALERT;
            default:    z = Z_IDLE;
        endcase
    end

    assign state    = state_q;
    assign step     = step_q;
    assign fail_cnt = fail_cnt_q;
    assign unlock   = unlock_q;

endmodule

// File: tb/tb_switch_seq_lock.sv
// Self-checking bench for switch_seq_lock (default parameters, no synchroniser).
// A table of directed vectors, hand-written multi-cycle sequences, and a
// randomized phase all run against a countdown-based reference model.
module tb_switch_seq_lock;

    localparam int SEQ_LEN     = 4;
    localparam int TIMEOUT     = 16;
    localparam int OPEN_CYC    = 8;
    localparam int MAX_FAIL    = 3;
    localparam int LOCKOUT_CYC = 32;

    localparam int S_IDLE = 0, S_ENTRY = 1, S_OPEN = 2, S_BAD = 3, S_LOCK = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sw = '0;
    logic       code_we = 1'b0;
    logic [7:0] code_in = '0;
    logic [2:0] state;
    logic [1:0] z;
    logic [2:0] step;
    logic [1:0] fail_cnt;
    logic       unlock;

    switch_seq_lock dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .code_we  (code_we),
        .code_in  (code_in),
        .state    (state),
        .z        (z),
        .step     (step),
        .fail_cnt (fail_cnt),
        .unlock   (unlock)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit rand_phase = 0;
    int cyc_no = 0;

    // ---------------- reference model ----------------
    int         m_mode, m_step, m_fail, m_left, m_unlock;
    logic [3:0] m_prev;
    int         m_code[SEQ_LEN];

    function automatic int z_of(input int mode);
        if (mode == S_OPEN) return 2;
        if (mode == S_BAD || mode == S_LOCK) return 3;
        return 1;
    endfunction

    task automatic model_reset();
        m_mode = S_IDLE; m_step = 0; m_fail = 0; m_left = 0; m_unlock = 0;
        m_prev = '0;
        for (int i = 0; i < SEQ_LEN; i++) m_code[i] = i % 4;
    endtask

    task automatic model_load(input logic [7:0] ci);
        for (int i = 0; i < SEQ_LEN; i++) m_code[i] = int'((ci >> (2 * i)) & 8'd3);
        m_step = 0;
        m_mode = S_IDLE;
    endtask

    task automatic model_press(input int ones, input int pos);
        if (ones == 1 && pos == m_code[m_step]) begin
            m_step++;
            if (m_step == SEQ_LEN) begin
                m_mode = S_OPEN; m_left = OPEN_CYC; m_fail = 0; m_unlock = 1;
            end else begin
                m_mode = S_ENTRY; m_left = TIMEOUT;
            end
        end else begin
            m_mode = S_BAD; m_step = 0;
            if (m_fail < MAX_FAIL) m_fail++;
        end
    endtask

    task automatic model_step(input logic [3:0] s, input logic we, input logic [7:0] ci);
        bit pr;
        int ones, pos;
        pr = (m_prev == 4'd0) && (s != 4'd0);
        m_prev = s;
        ones = $countones(s);
        pos = 0;
        for (int i = 0; i < 4; i++) if (s[i]) pos = i;
        m_unlock = 0;
        case (m_mode)
            S_IDLE:  if (we) model_load(ci); else if (pr) model_press(ones, pos);
            S_ENTRY: begin
                if (pr) model_press(ones, pos);
                else begin
                    m_left--;
                    if (m_left == 0) begin m_mode = S_IDLE; m_step = 0; end
                end
            end
            S_OPEN: begin
                if (we) model_load(ci);
                else begin
                    m_left--;
                    if (m_left == 0) begin m_mode = S_IDLE; m_step = 0; end
                end
            end
            S_BAD: begin
                if (m_fail == MAX_FAIL) begin m_mode = S_LOCK; m_left = LOCKOUT_CYC; end
                else m_mode = S_IDLE;
            end
            default: begin
                m_left--;
                if (m_left == 0) begin m_mode = S_IDLE; m_fail = 0; end
            end
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", nm, cyc_no, act, exp);
        end
    endtask

    task automatic compare_model();
        chk("model.state", int'(state), m_mode);
        chk("model.z", int'(z), z_of(m_mode));
        if (m_mode != S_OPEN) chk("model.step", int'(step), m_step);
        chk("model.fail_cnt", int'(fail_cnt), m_fail);
        chk("model.unlock", int'(unlock), m_unlock);
    endtask

    task automatic cyc(input logic [3:0] s, input logic we, input logic [7:0] ci, input logic rst);
        logic [3:0] prev_sw;
        prev_sw = sw;
        sw = s; code_we = we; code_in = ci; reset = rst;
        @(posedge clk);
        #1;
        cyc_no++;
        if (rst) model_reset();
        else model_step(s, we, ci);
        if (!rand_phase || we || rst || (s != prev_sw && s != 4'd0))
            $display("cyc=%0d sw=%b we=%0d rst=%0d -> state=%0d z=%b step=%0d fail_cnt=%0d unlock=%0d",
                     cyc_no, s, we, rst, state, z, step, fail_cnt, unlock);
        compare_model();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0] sw;
        int st;
        int zz;
        int stp;
        int fc;
        int ul;
    } vec_t;

    vec_t tbl[21];

    initial begin
        tbl[0]  = '{4'b0001, 1, 1, 1, 0, 0};
        tbl[1]  = '{4'b0000, 1, 1, 1, 0, 0};
        tbl[2]  = '{4'b0010, 1, 1, 2, 0, 0};
        tbl[3]  = '{4'b0000, 1, 1, 2, 0, 0};
        tbl[4]  = '{4'b0100, 1, 1, 3, 0, 0};
        tbl[5]  = '{4'b0000, 1, 1, 3, 0, 0};
        tbl[6]  = '{4'b1000, 2, 2, 4, 0, 1};
        for (int i = 7; i <= 13; i++) tbl[i] = '{4'b0000, 2, 2, 4, 0, 0};
        tbl[14] = '{4'b0000, 0, 1, 0, 0, 0};
        tbl[15] = '{4'b0001, 1, 1, 1, 0, 0};
        tbl[16] = '{4'b0000, 1, 1, 1, 0, 0};
        tbl[17] = '{4'b0100, 3, 3, 0, 1, 0};
        tbl[18] = '{4'b0000, 0, 1, 0, 1, 0};
        tbl[19] = '{4'b0011, 3, 3, 0, 2, 0};
        tbl[20] = '{4'b0000, 0, 1, 0, 2, 0};

        // Reset state
        model_reset();
        cyc(4'd0, 1'b0, 8'd0, 1'b1);
        cyc(4'd0, 1'b0, 8'd0, 1'b1);
        chk("reset.state", int'(state), 0);
        chk("reset.z", int'(z), 1);
        chk("reset.step", int'(step), 0);
        chk("reset.fail_cnt", int'(fail_cnt), 0);
        chk("reset.unlock", int'(unlock), 0);

        // Unlock with default code, wrong press, bad press
        for (int i = 0; i < 21; i++) begin
            cyc(tbl[i].sw, 1'b0, 8'd0, 1'b0);
            chk("tbl.state", int'(state), tbl[i].st);
            chk("tbl.z", int'(z), tbl[i].zz);
            if (tbl[i].st != S_OPEN) chk("tbl.step", int'(step), tbl[i].stp);
            chk("tbl.fail_cnt", int'(fail_cnt), tbl[i].fc);
            chk("tbl.unlock", int'(unlock), tbl[i].ul);
        end

        // Third failure leads to lockout; presses and code_we ignored there
        cyc(4'b0010, 1'b0, 8'd0, 1'b0);
        chk("lock.fail_state", int'(state), 3);
        chk("lock.fail_cnt", int'(fail_cnt), 3);
        cyc(4'b0000, 1'b0, 8'd0, 1'b0);
        chk("lock.enter", int'(state), 4);
        chk("lock.z", int'(z), 3);
        for (int i = 0; i < LOCKOUT_CYC - 1; i++)
            cyc((i % 2 == 0) ? 4'b0001 : 4'b0000, (i == 5), 8'h4F, 1'b0);
        chk("lock.last_cycle", int'(state), 4);
        cyc(4'b0000, 1'b0, 8'd0, 1'b0);
        chk("lock.exit_state", int'(state), 0);
        chk("lock.exit_fail_cnt", int'(fail_cnt), 0);

        // Timeout from ENTRY keeps fail_cnt; code unchanged by ignored write
        cyc(4'b0010, 1'b0, 8'd0, 1'b0);
        cyc(4'b0000, 1'b0, 8'd0, 1'b0);
        cyc(4'b0001, 1'b0, 8'd0, 1'b0);
        chk("tmo.first_press", int'(step), 1);
        for (int i = 0; i < TIMEOUT - 1; i++) cyc(4'b0000, 1'b0, 8'd0, 1'b0);
        chk("tmo.before", int'(state), 1);
        cyc(4'b0000, 1'b0, 8'd0, 1'b0);
        chk("tmo.state", int'(state), 0);
        chk("tmo.step", int'(step), 0);
        chk("tmo.fail_cnt", int'(fail_cnt), 1);

        // code_we wins over a simultaneous press; new code 3,3,0,1 opens
        cyc(4'b0001, 1'b1, 8'h4F, 1'b0);
        chk("we.state", int'(state), 0);
        chk("we.step", int'(step), 0);
        cyc(4'b0000, 1'b0, 8'd0, 1'b0);
        cyc(4'b1000, 1'b0, 8'd0, 1'b0);
        chk("we.step1", int'(step), 1);
        cyc(4'b0000, 1'b0, 8'd0, 1'b0);
        cyc(4'b1000, 1'b0, 8'd0, 1'b0);
        cyc(4'b0000, 1'b0, 8'd0, 1'b0);
        cyc(4'b0001, 1'b0, 8'd0, 1'b0);
        cyc(4'b0000, 1'b0, 8'd0, 1'b0);
        cyc(4'b0010, 1'b0, 8'd0, 1'b0);
        chk("we.open", int'(state), 2);
        chk("we.unlock", int'(unlock), 1);
        for (int i = 0; i < OPEN_CYC; i++) cyc(4'b0000, 1'b0, 8'd0, 1'b0);
        chk("we.open_exit", int'(state), 0);
        cyc(4'b1000, 1'b0, 8'd0, 1'b0);
        chk("we.code_kept", int'(step), 1);
        cyc(4'b0000, 1'b0, 8'd0, 1'b0);

        // Reset mid-entry restores everything including the default code
        cyc(4'b0000, 1'b0, 8'd0, 1'b1);
        chk("rst.state", int'(state), 0);
        chk("rst.z", int'(z), 1);
        chk("rst.step", int'(step), 0);
        chk("rst.fail_cnt", int'(fail_cnt), 0);
        chk("rst.unlock", int'(unlock), 0);
        cyc(4'b0001, 1'b0, 8'd0, 1'b0);
        chk("rst.default_code", int'(step), 1);
        cyc(4'b0000, 1'b0, 8'd0, 1'b0);

        // Randomized phase against the model
        rand_phase = 1;
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] s;
            logic       we, rst;
            logic [7:0] ci;
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 4) s = 4'd0;
            else if (r <= 8) begin
                if ($urandom_range(0, 1) == 1 && m_step < SEQ_LEN)
                    s = 4'(1 << m_code[m_step]);
                else
                    s = 4'(1 << (r - 5));
            end else s = 4'($urandom_range(1, 15));
            we  = ($urandom_range(0, 19) == 0);
            ci  = 8'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            cyc(s, we, ci, rst);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
